// File: rtl/seg_disp_pkg.sv
// Shared constants for the multiplexed 7-segment display: glyphs, modes, converter states.
package seg_disp_pkg;

    // Active-low {a,b,c,d,e,f,g}; all segments off.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Decimal digit glyphs 0-9, active-low {a..g}.
    localparam logic [6:0] DIGIT_GLYPH [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    localparam logic [1:0] MODE_NUM   = 2'd0;
    localparam logic [1:0] MODE_MSG   = 2'd1;
    localparam logic [1:0] MODE_ALERT = 2'd2;
    localparam logic [1:0] MODE_OFF   = 2'd3;

    typedef logic [1:0] conv_state_t;
    localparam conv_state_t ST_IDLE   = 2'd0;
    localparam conv_state_t ST_SHIFT  = 2'd1;
    localparam conv_state_t ST_COMMIT = 2'd2;

    // Glyph lookup; non-decimal nibbles show blank.
    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        if (d < 4'd10) begin
            return DIGIT_GLYPH[d];
        end
        return SEG_BLANK;
    endfunction

    // 10^n, used to derive the clamp limit at elaboration time.
    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with input clamp and committed output.
module bin2bcd_seq
    import seg_disp_pkg::*;
#(
    parameter int unsigned VALUE_W    = 10,
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [VALUE_W-1:0]      value,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(VALUE_W + 1);
    localparam logic [63:0] LIMIT   = pow10(NUM_DIGITS);
    localparam logic [63:0] MAX_VAL = LIMIT - 64'd1;

    conv_state_t        state_q;
    logic [VALUE_W-1:0] bin_q;
    logic [BCD_W-1:0]   scratch_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BCD_W-1:0]   adj;
    logic [63:0]        value_ext;
    logic [VALUE_W-1:0] clamped;

    // Values that do not fit in NUM_DIGITS decimal digits saturate to all 9s; the
    // truncated MAX_VAL is only selected when it is known to fit in VALUE_W bits.
    assign value_ext = 64'(value);
    assign clamped   = (value_ext >= LIMIT) ? MAX_VAL[VALUE_W-1:0] : value;

    // Add-3 correction on every nibble that will overflow past 9 after the shift.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Converter FSM: capture, VALUE_W shift steps, then a single-cycle commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        bin_q     <= clamped;
                        scratch_q <= '0;
                        cnt_q     <= '0;
                        state_q   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    scratch_q <= {adj[BCD_W-2:0], bin_q[VALUE_W-1]};
                    bin_q     <= bin_q << 1;
                    cnt_q     <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(VALUE_W - 1)) begin
                        state_q <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    bcd_q   <= scratch_q;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_COMMIT);
    assign bcd  = bcd_q;

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment driver: load queueing, digit scan, blink sequencing, mode mux.
module seg_scan_display
    import seg_disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned VALUE_W     = 10,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 25000000,
    parameter int unsigned LZ_BLANK    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [VALUE_W-1:0]      value,
    input  logic                    value_valid,
    input  logic [1:0]              mode,
    input  logic [7*NUM_DIGITS-1:0] msg,
    output logic                    busy,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              seg
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned REF_W = $clog2(REFRESH_DIV);
    localparam int unsigned BLK_W = $clog2(BLINK_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic                    conv_busy, conv_done, conv_idle, conv_start;
    logic [VALUE_W-1:0]      conv_value;
    logic [4*NUM_DIGITS-1:0] disp_bcd;
    logic                    pend_q, busy_q;
    logic [VALUE_W-1:0]      pend_val_q;
    logic [REF_W-1:0]        refresh_q;
    logic [IDX_W-1:0]        idx_q;
    logic [BLK_W-1:0]        blink_q;
    logic [1:0]              phase_q, mode_q, phase_eff;
    logic                    mode_changed;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    seen;
    logic [6:0]              num_seg, msg_seg, seg_d, seg_q;
    logic [NUM_DIGITS-1:0]   anode_d, anode_q;

    // A fresh strobe beats a pending value when the converter is free (last wins).
    assign conv_idle  = !(conv_busy || conv_done);
    assign conv_start = conv_idle && (value_valid || pend_q);
    assign conv_value = value_valid ? value : pend_val_q;

    bin2bcd_seq #(
        .VALUE_W   (VALUE_W),
        .NUM_DIGITS(NUM_DIGITS)
    ) u_conv (
        .clk  (clk),
        .rst_n(rst_n),
        .start(conv_start),
        .value(conv_value),
        .busy (conv_busy),
        .done (conv_done),
        .bcd  (disp_bcd)
    );

    // One-deep pending load; busy is registered so it falls only once the display is current.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            if (value_valid && !conv_idle) begin
                pend_q     <= 1'b1;
                pend_val_q <= value;
            end else if (conv_start) begin
                pend_q <= 1'b0;
            end
            busy_q <= value_valid || !conv_idle || pend_q;
        end
    end

    // Refresh divider and digit index, scanning from the MSD down to digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_q <= '0;
            idx_q     <= LAST_IDX;
        end else if (refresh_q == REF_W'(REFRESH_DIV - 1)) begin
            refresh_q <= '0;
            idx_q     <= (idx_q == '0) ? LAST_IDX : idx_q - 1'b1;
        end else begin
            refresh_q <= refresh_q + 1'b1;
        end
    end

    // Blink divider and phase; a mode change restarts the sequence at phase 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_NUM;
            blink_q <= '0;
            phase_q <= 2'd0;
        end else begin
            mode_q <= mode;
            if (mode_changed) begin
                blink_q <= '0;
                phase_q <= 2'd0;
            end else if (blink_q == BLK_W'(BLINK_DIV - 1)) begin
                blink_q <= '0;
                phase_q <= phase_q + 2'd1;
            end else begin
                blink_q <= blink_q + 1'b1;
            end
        end
    end

    assign mode_changed = (mode != mode_q);

    // Leading-zero mask: digits above the most significant non-zero digit; digit 0 never.
    always_comb begin
        seen     = 1'b0;
        lz_blank = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            if (disp_bcd[4*i +: 4] != 4'd0) begin
                seen = 1'b1;
            end
            lz_blank[i] = !seen && (i != 0);
        end
    end

    // Mode mux for the digit currently being lit.
    always_comb begin
        num_seg   = ((LZ_BLANK != 0) && lz_blank[idx_q]) ? SEG_BLANK
                                                         : digit_glyph(disp_bcd[4*idx_q +: 4]);
        msg_seg   = msg[7*idx_q +: 7];
        // The output in the cycle of a mode change already shows phase 0.
        phase_eff = mode_changed ? 2'd0 : phase_q;
        anode_d   = ~(NUM_DIGITS'(1) << idx_q);
        seg_d     = SEG_BLANK;
        case (mode)
            MODE_NUM: seg_d = num_seg;
            MODE_MSG: seg_d = msg_seg;
            MODE_ALERT: begin
                case (phase_eff)
                    2'd0:    seg_d = msg_seg;
                    2'd2:    seg_d = num_seg;
                    default: seg_d = SEG_BLANK;
                endcase
            end
            default: begin
                seg_d   = SEG_BLANK;
                anode_d = '1;
            end
        endcase
    end

    // Anode and segments are registered together so they switch in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_q <= '1;
            seg_q   <= SEG_BLANK;
        end else begin
            anode_q <= anode_d;
            seg_q   <= seg_d;
        end
    end

    assign busy  = busy_q;
    assign anode = anode_q;
    assign seg   = seg_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display against an arithmetic reference model.
module tb_seg_scan_display;

    localparam int R  = 4;
    localparam int B  = 8;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] GY = 7'b1000100;
    localparam logic [6:0] GO = 7'b0000001;
    localparam logic [6:0] GU = 7'b1000001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  value = '0;
    logic        value_valid = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [27:0] msg4 = '0;
    logic [20:0] msg3 = '0;
    logic        busy4, busy3;
    logic [3:0]  anode4;
    logic [2:0]  anode3;
    logic [6:0]  seg4, seg3;

    int edges;
    int npass = 0;
    int nfail = 0;
    int ntotal = 0;
    int num_val = 0;
    int astart = 0;

    always #5 clk = ~clk;

    seg_scan_display #(
        .NUM_DIGITS(4), .VALUE_W(10), .REFRESH_DIV(R), .BLINK_DIV(B), .LZ_BLANK(1)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .value(value), .value_valid(value_valid), .mode(mode),
        .msg(msg4), .busy(busy4), .anode(anode4), .seg(seg4)
    );

    seg_scan_display #(
        .NUM_DIGITS(3), .VALUE_W(10), .REFRESH_DIV(R), .BLINK_DIV(B), .LZ_BLANK(1)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .value(value), .value_valid(value_valid), .mode(mode),
        .msg(msg3), .busy(busy3), .anode(anode3), .seg(seg3)
    );

    // Number of active edges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    function automatic logic [6:0] ref_glyph(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return BL;
        endcase
    endfunction

    function automatic int pow10i(input int n);
        int p = 1;
        for (int k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    // Digit lit by the output register after edge e (e >= 1).
    function automatic int lit_digit(input int e, input int n);
        return (n - 1) - (((e - 1) / R) % n);
    endfunction

    function automatic logic [6:0] ref_num(input int v, input int i, input int n);
        int lim, p, vv;
        lim = pow10i(n);
        vv = (v >= lim) ? lim - 1 : v;
        p = pow10i(i);
        if (i > 0 && vv < p) return BL;
        return ref_glyph((vv / p) % 10);
    endfunction

    function automatic logic [6:0] ref_seg(input int e, input int n, input logic [1:0] m,
                                           input int v, input logic [55:0] mv);
        int i, j, ph;
        i = lit_digit(e, n);
        j = e - astart;
        ph = (j <= 0) ? 0 : ((j - 1) / B) % 4;
        case (m)
            2'd0: return ref_num(v, i, n);
            2'd1: return mv[7*i +: 7];
            2'd2: begin
                if (ph == 0) return mv[7*i +: 7];
                if (ph == 2) return ref_num(v, i, n);
                return BL;
            end
            default: return BL;
        endcase
    endfunction

    function automatic logic [7:0] ref_anode(input int e, input int n, input logic [1:0] m);
        if (m == 2'd3) return 8'hFF;
        return ~(8'd1 << lit_digit(e, n));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntotal++;
        assert (obs === expv) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, expv, edges);
        end
    endtask

    // Compare one cycle of both displays with the model.
    task automatic check_outputs(input string tag);
        logic [7:0] ea;
        logic [6:0] es;
        ea = ref_anode(edges, 4, mode);
        es = ref_seg(edges, 4, mode, num_val, 56'(msg4));
        check({tag, "_anode4"}, 32'(anode4), 32'(ea[3:0]));
        check({tag, "_seg4"}, 32'(seg4), 32'(es));
        ea = ref_anode(edges, 3, mode);
        es = ref_seg(edges, 3, mode, num_val, 56'(msg3));
        check({tag, "_anode3"}, 32'(anode3), 32'(ea[2:0]));
        check({tag, "_seg3"}, 32'(seg3), 32'(es));
    endtask

    task automatic frames(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            check_outputs(tag);
        end
    endtask

    // Pulse a load and wait (bounded) for both converters to finish.
    task automatic strobe_wait(input int v);
        int k;
        value = 10'(v);
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        k = 0;
        while ((busy4 || busy3) && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("load_idle", 32'(busy4 | busy3), 32'd0);
        num_val = v;
    endtask

    initial begin
        int s, falls, v;
        logic prev;

        // Reset, then scan zero; reset again mid-scan.
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        frames("zero", 10);
        #2 rst_n = 1'b0;
        #1;
        check("rst_anode4", 32'(anode4), 32'hF);
        check("rst_seg4", 32'(seg4), 32'(BL));
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_anode3", 32'(anode3), 32'h7);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_anode4", 32'(anode4), 32'b0111);
        check_outputs("post_rst");

        // 507: busy for exactly 12 cycles, then blank/5/0/7.
        value = 10'd507;
        value_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            value_valid = 1'b0;
            check("busy507_hi", 32'(busy4), 32'd1);
        end
        @(negedge clk);
        check("busy507_lo", 32'(busy4), 32'd0);
        num_val = 507;
        frames("num507", 16);

        // 1023: fits in 4 digits, clamps to 999 on 3 digits.
        strobe_wait(1023);
        frames("clamp", 16);

        // Back-to-back loads during a conversion: 12 shown, 34 dropped, 56 shown.
        value = 10'd12;
        value_valid = 1'b1;
        s = edges + 1;
        falls = 0;
        prev = 1'b0;
        for (int it = 0; it < 32; it++) begin
            @(negedge clk);
            if (it == 0) value = 10'd34;
            if (it == 1) value = 10'd56;
            if (it == 2) value_valid = 1'b0;
            check("pend_busy", 32'(busy4), 32'(edges <= s + 23));
            if (prev && !busy4) falls++;
            prev = busy4;
            if (edges >= s + 12) begin
                num_val = (edges < s + 24) ? 12 : 56;
                check_outputs("pend_disp");
            end
        end
        check("pend_falls", 32'(falls), 32'd1);

        // Alert blink with "YOU"; leaving and re-entering restarts at the msg phase.
        msg4 = {BL, GY, GO, GU};
        msg3 = {GY, GO, GU};
        mode = 2'd2;
        astart = edges + 1;
        frames("alert", 4 * B + 4);
        mode = 2'd0;
        frames("alert_num", 5);
        mode = 2'd2;
        astart = edges + 1;
        frames("alert_re", 2 * B + 4);

        // Raw message mode with random segment patterns.
        msg4 = 28'($urandom);
        msg3 = 21'($urandom);
        mode = 2'd1;
        frames("msg", 16);

        // Random numbers.
        mode = 2'd0;
        for (int r = 0; r < 5; r++) begin
            v = int'($urandom_range(0, 1023));
            strobe_wait(v);
            frames("rand", 16);
        end

        // Zero with leading-zero blanking, then blank mode.
        strobe_wait(0);
        frames("zero_lz", 16);
        mode = 2'd3;
        frames("off", 8);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
Parametrised multiplexed 7-segment driver that replaces the fixed 4-digit score display.
- Converts a binary value to BCD with a sequential double-dabble engine, so there is no combinational divide/modulo chain.
- Scans NUM_DIGITS anodes from one clock using internal refresh and blink dividers.
- Supports number, raw-message and blinking alert modes (e.g. "YOU"/"LOSE" end-of-game screen).
- Sits between game-state/score logic and the board pins.

Parameters:
NUM_DIGITS, 4, number of digits/anodes (1..8)
VALUE_W, 10, width of binary input value
REFRESH_DIV, 100000, clk cycles each digit is lit (min 2)
BLINK_DIV, 25000000, clk cycles per blink phase (min 2)
LZ_BLANK, 1, 1 = suppress leading zeros in number display

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
value  in  VALUE_W  binary number to show
value_valid  in  1  one-cycle load strobe for value
mode  in  2  0 = number, 1 = message, 2 = alert (blink cycle), 3 = blank
msg  in  7*NUM_DIGITS  raw segments; digit i at msg[7*i +: 7], active-low {a..g}
busy  out  1  converter running or a load pending
anode  out  NUM_DIGITS  active-low digit enables; bit i = digit i, bit NUM_DIGITS-1 = leftmost/MSD
seg  out  7  active-low {a,b,c,d,e,f,g}; "0" = 7'b0000001, blank = 7'b1111111

Behaviour:
Reset (async assert, sync release):
- anode = all 1s, seg = 7'b1111111, busy = 0.
- Displayed BCD = 0, refresh/blink counters = 0, digit index = NUM_DIGITS-1, blink phase = 0.

Converter FSM, states IDLE, SHIFT, COMMIT:
- IDLE, value_valid=1: capture value; if value >= 10^NUM_DIGITS, clamp to 10^NUM_DIGITS-1 (all 9s). busy=1 the next cycle.
- SHIFT: VALUE_W cycles. Each cycle: add 3 to every BCD nibble >= 5, then shift left one bit.
- COMMIT: copy the BCD scratch into the display register in a single cycle (no tearing). Return to IDLE; busy drops unless a load is pending.
- Latency: display register updated VALUE_W+2 cycles after the strobe.
- value_valid while busy: store in a one-deep pending register (last wins). Start it in the cycle after COMMIT.
- value_valid in the same cycle as COMMIT: goes to pending.

Scan:
- Refresh counter runs 0..REFRESH_DIV-1. On wrap, digit index decrements: NUM_DIGITS-1 down to 0, then back to NUM_DIGITS-1.
- anode has exactly one 0 bit, at the current index, except in mode 3 (all 1s).
- anode and seg are registered together and change in the same cycle.

Number glyphs:
- Decimal digit glyphs 0-9 per the team encoding.
- LZ_BLANK=1: digits above the most significant non-zero digit show blank. Digit 0 is always shown (value 0 shows a single "0").

Blink:
- Counter runs 0..BLINK_DIV-1. Phase (2 bits) increments on wrap.
- Mode 2 shows, by phase: 0 = msg, 1 = blank, 2 = number, 3 = blank.
- Any change of mode resets the blink counter and phase to 0 on the next cycle. The scan continues unaffected.

Mode 1: seg = msg field of the current digit, passed through unmodified.

Decomposition:
- Package seg_disp_pkg: SEG_BLANK, 10-entry digit glyph constant array, mode encodings MODE_NUM/MODE_MSG/MODE_ALERT/MODE_OFF, FSM state typedef.
- Sub-module bin2bcd_seq, parametrised by VALUE_W and NUM_DIGITS, with start/busy/done handshake; it contains the double-dabble FSM and the clamp.
- The top module contains scan, blink, mode mux and pending register.

Test Plan:
- Reset mid-scan (REFRESH_DIV=4) -> anode=4'b1111 and seg=7'b1111111 immediately; after release first anode=4'b0111.
- mode=0, value=10'd507 strobe -> busy high for 12 cycles; digits read blank,"5","0","7" (7'b1111111,7'b0100100,7'b0000001,7'b0001111).
- value=10'd1023 with NUM_DIGITS=3 -> clamps to "999" on all three digits.
- Strobes of 12, then 34, then 56 on consecutive cycles during a conversion -> displays "12" then "56"; 34 never displayed; busy deasserts once.
- mode=2, BLINK_DIV=8, msg="YOU" -> phases msg/blank/number/blank every 8 cycles; switching to mode 0 and back restarts at phase 0 (msg).
- value=0, LZ_BLANK=1 -> only the rightmost digit shows 7'b0000001; mode 3 -> anode all 1s.
